// File: rtl/line_buffer_9rows.sv
// -----------------------------------------------------------------------------
// line_buffer_9rows
//   Upstream feeder for the 9x9 window modulator. Takes a raster-order 8-bit
//   pixel stream (one pixel per cycle with valid_i=1) for a ROWS x COLS padded
//   image. Eight line memories keep the previous eight rows. Once row 8 is
//   reached, every accepted pixel yields one 9-tall column (d0_o = row r-8,
//   oldest, .. d8_o = row r, current) with a single-cycle done_o strobe.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   data_i[7:0]   incoming pixel
//   valid_i       pixel accepted on every rising edge where it is 1
//   d0_o..d8_o    vertically aligned column, rows r-8 .. r, column c
//   done_o        d0_o..d8_o hold a valid column (one-cycle strobe)
//   frame_done_o  one-cycle pulse the cycle after the last done_o of a frame
// -----------------------------------------------------------------------------

// One line memory: asynchronous read of the old word, synchronous write.
// No reset on the array; its contents are don't-care after reset because the
// FILL phase rewrites every location before anything is emitted.
module line_buffer_9rows_line #(
    parameter int DEPTH = 11,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

module line_buffer_9rows #(
    parameter int ROWS = 11,
    parameter int COLS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic [7:0] d0_o,
    output logic [7:0] d1_o,
    output logic [7:0] d2_o,
    output logic [7:0] d3_o,
    output logic [7:0] d4_o,
    output logic [7:0] d5_o,
    output logic [7:0] d6_o,
    output logic [7:0] d7_o,
    output logic [7:0] d8_o,
    output logic       done_o,
    output logic       frame_done_o
);

    localparam int NUM_LINES = 8;
    localparam int PIX_W     = 8;
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW        = $clog2(ROWS);

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_FILLN = RW'(NUM_LINES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;

    logic col_last, row_last, fill_last;
    logic stream_acc, frame_last;

    // line_rd[k] is line k at col_cnt before this edge's write
    logic [NUM_LINES-1:0][PIX_W-1:0] line_rd;
    logic [NUM_LINES-1:0][PIX_W-1:0] line_wd;

    logic [NUM_LINES:0][PIX_W-1:0]   d_q;
    logic                            done_q;
    // end-of-frame flag delayed two edges so it lands after the final done_o
    logic [1:0]                      eof_pipe;

    assign col_last  = (col_cnt == COL_LAST);
    assign row_last  = (row_cnt == ROW_LAST);
    assign fill_last = (row_cnt == ROW_FILLN) && col_last;

    // ---------------------------------------------------------------- lines
    // Rows shift up one line per accepted pixel at the current column:
    // line_k <= line_(k+1), line7 <= incoming pixel.
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        if (k == NUM_LINES - 1) begin : g_top
            assign line_wd[k] = data_i;
        end else begin : g_mid
            assign line_wd[k] = line_rd[k+1];
        end

        line_buffer_9rows_line #(
            .DEPTH (COLS),
            .AW    (CW),
            .W     (PIX_W)
        ) u_line (
            .clk   (clk),
            .we    (valid_i),
            .addr  (col_cnt),
            .wdata (line_wd[k]),
            .rdata (line_rd[k])
        );
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i) state_nxt = FILL;
            FILL:    if (valid_i && fill_last) state_nxt = STREAM;
            STREAM:  if (valid_i && row_last && col_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stream_acc = 1'b0;
        frame_last = 1'b0;
        if (state == STREAM && valid_i) begin
            stream_acc = 1'b1;
            frame_last = row_last && col_last;
        end
    end

    // ------------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (valid_i) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    // --------------------------------------------------------------- output
    // d_q follows every accepted pixel (also during FILL); done_o is what
    // tells the consumer when the column is meaningful.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q      <= '0;
            done_q   <= 1'b0;
            eof_pipe <= '0;
        end else begin
            if (valid_i) d_q <= {data_i, line_rd};
            done_q   <= stream_acc;
            eof_pipe <= {eof_pipe[0], frame_last};
        end
    end

    assign d0_o         = d_q[0];
    assign d1_o         = d_q[1];
    assign d2_o         = d_q[2];
    assign d3_o         = d_q[3];
    assign d4_o         = d_q[4];
    assign d5_o         = d_q[5];
    assign d6_o         = d_q[6];
    assign d7_o         = d_q[7];
    assign d8_o         = d_q[8];
    assign done_o       = done_q;
    assign frame_done_o = eof_pipe[1];

endmodule

// File: tb/tb_line_buffer_9rows.sv
module tb_line_buffer_9rows;

    localparam int ROWS = 11;
    localparam int COLS = 11;
    localparam int NPIX = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
    logic       done_o, frame_done_o;

    line_buffer_9rows #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .d0_o         (d0_o),
        .d1_o         (d1_o),
        .d2_o         (d2_o),
        .d3_o         (d3_o),
        .d4_o         (d4_o),
        .d5_o         (d5_o),
        .d6_o         (d6_o),
        .d7_o         (d7_o),
        .d8_o         (d8_o),
        .done_o       (done_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    logic [7:0] dv [9];
    always_comb begin
        dv[0] = d0_o; dv[1] = d1_o; dv[2] = d2_o;
        dv[3] = d3_o; dv[4] = d4_o; dv[5] = d5_o;
        dv[6] = d6_o; dv[7] = d7_o; dv[8] = d8_o;
    end

    // Reference model: the image as received, indexed by (row, col) derived
    // from a running pixel index within the frame.
    logic [7:0] img [ROWS][COLS];
    logic [7:0] exp_d [9];
    bit  exp_done, exp_fd, fd_p1, in_rst;
    int  idx;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  done_cnt, fd_cnt;

    typedef struct {
        int         r;
        int         c;
        logic [7:0] d0;
        logic [7:0] d4;
        logic [7:0] d8;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int p);
        logic [7:0] v;
        v = 8'(((p / COLS) << 4) | (p % COLS));
        return v;
    endfunction

    // Drive one cycle, advance the model at the edge, check on the negedge.
    task automatic step(input logic v, input logic [7:0] d);
        int r, c;
        valid_i = v;
        data_i  = d;
        @(posedge clk);
        if (!rst) begin
            idx = 0; exp_done = 0; exp_fd = 0; fd_p1 = 0; in_rst = 1;
        end else begin
            in_rst   = 0;
            exp_fd   = fd_p1;
            fd_p1    = 0;
            exp_done = 0;
            if (v) begin
                r = idx / COLS;
                c = idx % COLS;
                img[r][c] = d;
                if (r >= 8) begin
                    exp_done = 1;
                    for (int k = 0; k < 9; k++) exp_d[k] = img[r-8+k][c];
                end
                fd_p1 = (idx == NPIX - 1);
                idx   = (idx + 1) % NPIX;
            end
        end
        @(negedge clk);
        chk("done_o", 32'(done_o), 32'(exp_done));
        chk("frame_done_o", 32'(frame_done_o), 32'(exp_fd));
        if (exp_done)
            for (int k = 0; k < 9; k++) chk($sformatf("d%0d_o", k), 32'(dv[k]), 32'(exp_d[k]));
        if (in_rst)
            for (int k = 0; k < 9; k++) chk($sformatf("rst d%0d_o", k), 32'(dv[k]), 32'h0);
        if (done_o === 1'b1) done_cnt++;
        if (frame_done_o === 1'b1) fd_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic chk_frame(input string name);
        chk({name, " done count"}, 32'(done_cnt), 32'((ROWS - 8) * COLS));
        chk({name, " frame_done count"}, 32'(fd_cnt), 32'd1);
        done_cnt = 0;
        fd_cnt   = 0;
    endtask

    initial begin
        int pos;
        tbl[0] = '{r: 8,  c: 0,  d0: 8'h00, d4: 8'h40, d8: 8'h80};
        tbl[1] = '{r: 8,  c: 10, d0: 8'h0A, d4: 8'h4A, d8: 8'h8A};
        tbl[2] = '{r: 9,  c: 3,  d0: 8'h13, d4: 8'h53, d8: 8'h93};
        tbl[3] = '{r: 10, c: 10, d0: 8'h2A, d4: 8'h6A, d8: 8'hAA};
        idx = 0; exp_done = 0; exp_fd = 0; fd_p1 = 0; in_rst = 1;
        done_cnt = 0; fd_cnt = 0;

        // reset state, then reset held with valid data driving
        #1;
        chk("reset done_o", 32'(done_o), 32'h0);
        chk("reset frame_done_o", 32'(frame_done_o), 32'h0);
        chk("reset d0_o", 32'(d0_o), 32'h0);
        chk("reset d8_o", 32'(d8_o), 32'h0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
        rst = 1'b1;
        done_cnt = 0; fd_cnt = 0;

        // directed frame, data = row*16+col, continuous valid, spot table
        pos = 0;
        for (int t = 0; t < 4; t++) begin
            while (pos <= tbl[t].r * COLS + tbl[t].c) begin
                if (pos == 8 * COLS) chk("no done before (8,0)", 32'(done_cnt), 32'h0);
                step(1'b1, pix(pos));
                pos++;
            end
            chk($sformatf("tbl%0d done_o", t), 32'(done_o), 32'h1);
            chk($sformatf("tbl%0d d0_o", t), 32'(d0_o), 32'(tbl[t].d0));
            chk($sformatf("tbl%0d d4_o", t), 32'(d4_o), 32'(tbl[t].d4));
            chk($sformatf("tbl%0d d8_o", t), 32'(d8_o), 32'(tbl[t].d8));
        end
        idle(2);
        chk_frame("directed");

        // gapped: valid toggles 1,0,1,0
        for (int p = 0; p < NPIX; p++) begin
            step(1'b1, pix(p));
            step(1'b0, 8'($urandom));
        end
        idle(2);
        chk_frame("gapped");

        // back-to-back: random frame, then 0xF0 frame starting next cycle
        for (int p = 0; p < NPIX; p++) step(1'b1, 8'($urandom));
        done_cnt = 0; fd_cnt = 0;
        for (int p = 0; p < NPIX; p++) begin
            step(1'b1, 8'hF0);
            if (p == 8 * COLS - 1) chk("b2b no done in fill", 32'(done_cnt), 32'h0);
            if (done_o === 1'b1) begin
                chk("b2b d0_o", 32'(d0_o), 32'hF0);
                chk("b2b d8_o", 32'(d8_o), 32'hF0);
            end
        end
        idle(2);
        // the random frame's frame_done_o lands inside this window too
        chk("b2b done count", 32'(done_cnt), 32'((ROWS - 8) * COLS));
        chk("b2b frame_done count", 32'(fd_cnt), 32'd2);
        done_cnt = 0; fd_cnt = 0;

        // mid-frame reset after pixel (9,5), then a fresh gapped random frame
        for (int p = 0; p <= 9 * COLS + 5; p++) step(1'b1, 8'($urandom));
        rst = 1'b0;
        step(1'b1, 8'($urandom));
        rst = 1'b1;
        done_cnt = 0; fd_cnt = 0;
        pos = 0;
        while (pos < NPIX) begin
            if ($urandom_range(3, 0) == 0) begin
                step(1'b0, 8'($urandom));
            end else begin
                step(1'b1, 8'($urandom));
                if (pos == 8 * COLS) begin
                    chk("post-rst first done_o", 32'(done_o), 32'h1);
                    chk("post-rst first d0_o", 32'(d0_o), 32'(img[0][0]));
                    chk("post-rst done count at (8,0)", 32'(done_cnt), 32'h1);
                end
                pos++;
            end
        end
        idle(2);
        chk_frame("post-reset");

        // random frames with random gaps, back to back
        for (int f = 0; f < 2; f++) begin
            pos = 0;
            while (pos < NPIX) begin
                if ($urandom_range(2, 0) == 0) step(1'b0, 8'($urandom));
                else begin
                    step(1'b1, 8'($urandom));
                    pos++;
                end
            end
        end
        idle(2);
        chk("random done count", 32'(done_cnt), 32'(2 * (ROWS - 8) * COLS));
        chk("random frame_done count", 32'(fd_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_9rows.md
Name: line_buffer_9rows

Overview:
- Upstream feeder for the 9x9 window modulator.
- Accepts a raster-order 8-bit pixel stream, one pixel per accepted cycle, for a ROWS x COLS padded image.
- Stores the last 8 rows in line memories.
- Once 9 rows are available, presents each column as 9 vertically aligned pixels (d0_o oldest row .. d8_o current row) with a one-cycle done_o strobe.

Parameters:
ROWS, 11, image height in rows including padding; legal range 9..1023.
COLS, 11, image width in pixels including padding; legal range 1..1023.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
data_i  input  8  pixel of the incoming raster stream.
valid_i  input  1  data_i valid; pixel accepted on every rising edge with valid_i=1.
d0_o  output  8  pixel from row r-8 (oldest), column c.
d1_o  output  8  row r-7, column c.
d2_o  output  8  row r-6, column c.
d3_o  output  8  row r-5, column c.
d4_o  output  8  row r-4, column c.
d5_o  output  8  row r-3, column c.
d6_o  output  8  row r-2, column c.
d7_o  output  8  row r-1, column c.
d8_o  output  8  row r (current), column c.
done_o  output  1  d0_o..d8_o hold a valid column; one-cycle strobe per column.
frame_done_o  output  1  one-cycle pulse, the cycle after the last done_o of a frame.

Behaviour:
- Reset (rst=0, async):
  - d0_o..d8_o=0, done_o=0, frame_done_o=0.
  - col_cnt=0, row_cnt=0, state=IDLE.
  - Line memory contents are don't-care; no clear is required.
- Line memories:
  - line0..line7, each COLS x 8 bits, addressed by col_cnt.
  - On an accepted pixel: read all lines at col_cnt (old value), then write line_k[col]<=line_(k+1)[col] for k=0..6 and line7[col]<=data_i.
- Output registers:
  - Updated only on accepted pixels: d_k_o<=line_k[col] (old) for k=0..7, d8_o<=data_i.
  - Outputs otherwise hold their value.
- Latency: done_o rises exactly 1 cycle after the accepting edge of a pixel with row_cnt>=8.
- Counters:
  - col_cnt increments per accepted pixel and wraps COLS-1->0.
  - row_cnt increments on the col wrap; it wraps ROWS-1->0 on the last pixel of the frame.
  - valid_i=0 freezes counters, memories and outputs; done_o=0 that cycle.
- FSM:
  - IDLE: counters zero. Accepted pixel -> FILL (or STREAM directly when ROWS... not applicable, ROWS>=9).
  - FILL: rows 0..7 are being stored; done_o stays 0. Accepting pixel (7,COLS-1) -> STREAM.
  - STREAM: every accepted pixel produces done_o the next cycle. Accepting pixel (ROWS-1,COLS-1) -> IDLE, with a frame_done_o pulse 1 cycle after the final done_o (i.e. 2 cycles after that pixel's acceptance).
- A new frame may start on the cycle immediately after the last pixel; the previous frame's stale line data is never emitted, because FILL suppresses done_o.
- done_o count per frame = (ROWS-8)*COLS; for the defaults this is 33.
- Reset mid-frame: all state returns to the reset values immediately; the next accepted pixel is treated as (0,0).
- No backpressure: the downstream consumer must accept one column per done_o.

Test Plan:
- Reset: hold rst=0 for 3 cycles with valid_i=1 and random data -> all outputs 0, done_o=0. Release -> no done_o until 8 full rows have been streamed.
- Full frame, 11x11, data=row*16+col, valid_i continuous:
  - first done_o 1 cycle after pixel (8,0) is accepted.
  - at that cycle d0_o=0x00, d4_o=0x40, d8_o=0x80.
  - last done_o has d0_o=0x2A, d8_o=0xAA.
  - exactly 33 done_o strobes, then frame_done_o=1 on the next cycle.
- Gapped input: same frame with valid_i toggled 1,0,1,0 -> identical output sequence; done_o never asserted in a cycle following valid_i=0; frame_done_o still a single pulse.
- Back-to-back frames:
  - second frame (data=0xF0 fixed) starts the cycle after the first frame's last pixel.
  - no done_o during its first 88 accepted pixels.
  - then 33 strobes, all with d0_o..d8_o=0xF0.
- Mid-frame reset: assert rst=0 after pixel (9,5), then restart a fresh frame -> first done_o again only after pixel (8,0) of the new frame, with d0_o equal to the new frame's (0,0) value.
